ctrl_pipe_hazard: RTL and testbench

- Parametrised successor to the LEGv8 main decoder, located in the ID stage of the 5-stage pipelined core.
- Decodes the 11-bit opcode into the control bundle and adds optional instruction classes: CBNZ, ADDI/SUBI and unconditional B.
- Carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, inserts bubbles, applies branch flush, and keeps saturating stall and flush counters.

---
 rtl/ctrl_pipe_hazard_if.sv | 51 +++++
 rtl/ctrl_pipe_hazard.sv | 210 +++++++++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_hazard_if.sv
// ID-stage bundle between the hazard/control block and the datapath: decode inputs,
// the registered control fields of each later stage, and the performance counters.
interface ctrl_pipe_hazard_if #(
  parameter int CNT_W = 16
);
  logic [10:0]      op_id;
  logic [4:0]       rn_id;
  logic [4:0]       rm_id;
  logic [4:0]       rd_id;
  logic             flush_mem;

  logic             reg2loc_id;
  logic             illegal_id;
  logic             stall_if;

  logic             ex_alusrc;
  logic [1:0]       ex_aluop;
  logic [4:0]       ex_rd;

  logic             mem_memread;
  logic             mem_memwrite;
  logic             mem_branch;
  logic             mem_brnz;
  logic             mem_uncond;
  logic [4:0]       mem_rd;

  logic             wb_memtoreg;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output op_id, rn_id, rm_id, rd_id, flush_mem,
    input  reg2loc_id, illegal_id, stall_if,
    input  ex_alusrc, ex_aluop, ex_rd,
    input  mem_memread, mem_memwrite, mem_branch, mem_brnz, mem_uncond, mem_rd,
    input  wb_memtoreg, wb_regwrite, wb_rd,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  op_id, rn_id, rm_id, rd_id, flush_mem,
    output reg2loc_id, illegal_id, stall_if,
    output ex_alusrc, ex_aluop, ex_rd,
    output mem_memread, mem_memwrite, mem_branch, mem_brnz, mem_uncond, mem_rd,
    output wb_memtoreg, wb_regwrite, wb_rd,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// LEGv8 ID-stage main decoder with control pipeline (ID/EX, EX/MEM, MEM/WB),
// load-use bubble insertion, MEM-stage branch flush and saturating stall/flush counters.
module ctrl_pipe_hazard #(
  parameter bit EN_CBNZ   = 1'b1,
  parameter bit EN_IMM    = 1'b1,
  parameter bit EN_UNCOND = 1'b1,
  parameter bit HAZARD_EN = 1'b1,
  parameter int ZR_IDX    = 31,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  ctrl_pipe_hazard_if.slave bus
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [4:0]  ZR      = 5'(ZR_IDX);

  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       brnz;
    logic       uncond;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       brnz;
    logic       uncond;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       brnz;
    logic       uncond;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       memtoreg;
    logic       regwrite;
    logic [4:0] rd;
  } memwb_t;

  ctrl_t            dec;
  logic             illegal;
  logic             use_rn;
  logic             use_r2;
  logic [4:0]       src2;
  logic             hz;
  logic             stall;

  idex_t            idex_d,  idex_q;
  exmem_t           exmem_d, exmem_q;
  memwb_t           memwb_d, memwb_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // Main decode; use_rn/use_r2 record which register sources the class actually reads.
  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    use_rn  = 1'b0;
    use_r2  = 1'b0;
    if (bus.op_id == OP_ADD || bus.op_id == OP_SUB ||
        bus.op_id == OP_AND || bus.op_id == OP_ORR) begin
      dec.regwrite = 1'b1;
      dec.aluop    = 2'b10;
      use_rn       = 1'b1;
      use_r2       = 1'b1;
    end else if (bus.op_id == OP_LDUR) begin
      dec.alusrc   = 1'b1;
      dec.memtoreg = 1'b1;
      dec.regwrite = 1'b1;
      dec.memread  = 1'b1;
      use_rn       = 1'b1;
    end else if (bus.op_id == OP_STUR) begin
      dec.reg2loc  = 1'b1;
      dec.alusrc   = 1'b1;
      dec.memwrite = 1'b1;
      use_rn       = 1'b1;
      use_r2       = 1'b1;
    end else if (bus.op_id[10:3] == 8'b10110100) begin
      dec.reg2loc  = 1'b1;
      dec.branch   = 1'b1;
      dec.aluop    = 2'b01;
      use_r2       = 1'b1;
    end else if (EN_CBNZ && bus.op_id[10:3] == 8'b10110101) begin
      dec.reg2loc  = 1'b1;
      dec.branch   = 1'b1;
      dec.brnz     = 1'b1;
      dec.aluop    = 2'b01;
      use_r2       = 1'b1;
    end else if (EN_IMM && (bus.op_id[10:1] == 10'b1001000100 ||
                            bus.op_id[10:1] == 10'b1101000100)) begin
      dec.alusrc   = 1'b1;
      dec.regwrite = 1'b1;
      dec.aluop    = 2'b11;
      use_rn       = 1'b1;
    end else if (EN_UNCOND && bus.op_id[10:5] == 6'b000101) begin
      dec.branch   = 1'b1;
      dec.uncond   = 1'b1;
    end else begin
      illegal      = 1'b1;
    end
  end

  // A load in EX targeting a register this instruction reads forces one bubble.
  always_comb begin
    src2  = dec.reg2loc ? bus.rd_id : bus.rm_id;
    hz    = HAZARD_EN && idex_q.memread && (idex_q.rd != ZR) &&
            ((use_rn && bus.rn_id == idex_q.rd) || (use_r2 && src2 == idex_q.rd));
    stall = hz && !bus.flush_mem;
  end

  always_comb begin
    idex_d.alusrc     = dec.alusrc;
    idex_d.aluop      = dec.aluop;
    idex_d.memtoreg   = dec.memtoreg;
    idex_d.regwrite   = dec.regwrite;
    idex_d.memread    = dec.memread;
    idex_d.memwrite   = dec.memwrite;
    idex_d.branch     = dec.branch;
    idex_d.brnz       = dec.brnz;
    idex_d.uncond     = dec.uncond;
    idex_d.rd         = bus.rd_id;

    exmem_d.memtoreg  = idex_q.memtoreg;
    exmem_d.regwrite  = idex_q.regwrite;
    exmem_d.memread   = idex_q.memread;
    exmem_d.memwrite  = idex_q.memwrite;
    exmem_d.branch    = idex_q.branch;
    exmem_d.brnz      = idex_q.brnz;
    exmem_d.uncond    = idex_q.uncond;
    exmem_d.rd        = idex_q.rd;

    memwb_d.memtoreg  = exmem_q.memtoreg;
    memwb_d.regwrite  = exmem_q.regwrite;
    memwb_d.rd        = exmem_q.rd;

    stall_cnt_d       = stall_cnt_q;
    flush_cnt_d       = flush_cnt_q;

    if (bus.flush_mem) begin
      idex_d  = '0;
      exmem_d = '0;
      if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall) begin
      idex_d  = '0;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.reg2loc_id   = dec.reg2loc;
  assign bus.illegal_id   = illegal;
  assign bus.stall_if     = stall;
  assign bus.ex_alusrc    = idex_q.alusrc;
  assign bus.ex_aluop     = idex_q.aluop;
  assign bus.ex_rd        = idex_q.rd;
  assign bus.mem_memread  = exmem_q.memread;
  assign bus.mem_memwrite = exmem_q.memwrite;
  assign bus.mem_branch   = exmem_q.branch;
  assign bus.mem_brnz     = exmem_q.brnz;
  assign bus.mem_uncond   = exmem_q.uncond;
  assign bus.mem_rd       = exmem_q.rd;
  assign bus.wb_memtoreg  = memwb_q.memtoreg;
  assign bus.wb_regwrite  = memwb_q.regwrite;
  assign bus.wb_rd        = memwb_q.rd;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: a full-featured instance (A) and one with the optional
// classes disabled and 2-bit counters (B); expectations are queued per cycle and checked by a monitor.
module tb_ctrl_pipe_hazard;

  localparam int A = 0;
  localparam int B = 1;

  localparam int F_EX_ALUSRC    = 0;
  localparam int F_EX_ALUOP     = 1;
  localparam int F_EX_RD        = 2;
  localparam int F_MEM_MEMREAD  = 3;
  localparam int F_MEM_MEMWRITE = 4;
  localparam int F_MEM_BRANCH   = 5;
  localparam int F_MEM_BRNZ     = 6;
  localparam int F_MEM_UNCOND   = 7;
  localparam int F_MEM_RD       = 8;
  localparam int F_WB_MEMTOREG  = 9;
  localparam int F_WB_REGWRITE  = 10;
  localparam int F_WB_RD        = 11;
  localparam int F_STALL        = 12;
  localparam int F_ILLEGAL      = 13;
  localparam int F_REG2LOC      = 14;
  localparam int F_STALL_CNT    = 15;
  localparam int F_FLUSH_CNT    = 16;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101011;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  typedef struct {
    int    cyc;
    int    dut;
    int    sel;
    int    val;
    string name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc_cnt;
  int   checks;
  int   failures;
  bit   done;
  exp_t sb[$];

  ctrl_pipe_hazard_if #(.CNT_W(16)) bus_a ();
  ctrl_pipe_hazard_if #(.CNT_W(2))  bus_b ();

  ctrl_pipe_hazard #(
    .EN_CBNZ(1'b1), .EN_IMM(1'b1), .EN_UNCOND(1'b1), .HAZARD_EN(1'b1),
    .ZR_IDX(31), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  ctrl_pipe_hazard #(
    .EN_CBNZ(1'b0), .EN_IMM(1'b0), .EN_UNCOND(1'b0), .HAZARD_EN(1'b1),
    .ZR_IDX(31), .CNT_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int getField(int dut, int sel);
    int v;
    v = -1;
    if (dut == A) begin
      case (sel)
        F_EX_ALUSRC:    v = int'(bus_a.ex_alusrc);
        F_EX_ALUOP:     v = int'(bus_a.ex_aluop);
        F_EX_RD:        v = int'(bus_a.ex_rd);
        F_MEM_MEMREAD:  v = int'(bus_a.mem_memread);
        F_MEM_MEMWRITE: v = int'(bus_a.mem_memwrite);
        F_MEM_BRANCH:   v = int'(bus_a.mem_branch);
        F_MEM_BRNZ:     v = int'(bus_a.mem_brnz);
        F_MEM_UNCOND:   v = int'(bus_a.mem_uncond);
        F_MEM_RD:       v = int'(bus_a.mem_rd);
        F_WB_MEMTOREG:  v = int'(bus_a.wb_memtoreg);
        F_WB_REGWRITE:  v = int'(bus_a.wb_regwrite);
        F_WB_RD:        v = int'(bus_a.wb_rd);
        F_STALL:        v = int'(bus_a.stall_if);
        F_ILLEGAL:      v = int'(bus_a.illegal_id);
        F_REG2LOC:      v = int'(bus_a.reg2loc_id);
        F_STALL_CNT:    v = int'(bus_a.stall_cnt);
        F_FLUSH_CNT:    v = int'(bus_a.flush_cnt);
        default:        v = -1;
      endcase
    end else begin
      case (sel)
        F_EX_ALUSRC:    v = int'(bus_b.ex_alusrc);
        F_EX_ALUOP:     v = int'(bus_b.ex_aluop);
        F_EX_RD:        v = int'(bus_b.ex_rd);
        F_MEM_MEMREAD:  v = int'(bus_b.mem_memread);
        F_MEM_MEMWRITE: v = int'(bus_b.mem_memwrite);
        F_MEM_BRANCH:   v = int'(bus_b.mem_branch);
        F_MEM_BRNZ:     v = int'(bus_b.mem_brnz);
        F_MEM_UNCOND:   v = int'(bus_b.mem_uncond);
        F_MEM_RD:       v = int'(bus_b.mem_rd);
        F_WB_MEMTOREG:  v = int'(bus_b.wb_memtoreg);
        F_WB_REGWRITE:  v = int'(bus_b.wb_regwrite);
        F_WB_RD:        v = int'(bus_b.wb_rd);
        F_STALL:        v = int'(bus_b.stall_if);
        F_ILLEGAL:      v = int'(bus_b.illegal_id);
        F_REG2LOC:      v = int'(bus_b.reg2loc_id);
        F_STALL_CNT:    v = int'(bus_b.stall_cnt);
        F_FLUSH_CNT:    v = int'(bus_b.flush_cnt);
        default:        v = -1;
      endcase
    end
    return v;
  endfunction

  task automatic checkOutput(input exp_t e);
    int got;
    got = getField(e.dut, e.sel);
    checks++;
    if (got != e.val) begin
      failures++;
      $display("[TB] FAIL %s (dut %s, cycle %0d): got %0d expected %0d",
               e.name, (e.dut == A) ? "A" : "B", e.cyc, got, e.val);
    end
  endtask

  // Monitor: away from the active edge, retire every expectation scheduled for this cycle.
  always @(negedge clk) begin
    if (!done) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc <= cyc_cnt) begin
          checkOutput(sb[i]);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic expectAt(input int cyc, input int dut, input int sel, input int val,
                          input string name);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [10:0] op, input logic [4:0] rn,
                               input logic [4:0] rm, input logic [4:0] rd,
                               input logic flush);
    bus_a.op_id = op;  bus_a.rn_id = rn;  bus_a.rm_id = rm;  bus_a.rd_id = rd;
    bus_a.flush_mem = flush;
    bus_b.op_id = op;  bus_b.rn_id = rn;  bus_b.rm_id = rm;  bus_b.rd_id = rd;
    bus_b.flush_mem = flush;
  endtask

  task automatic idle();
    applyStimulus(11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    checks   = 0;
    failures = 0;
    done     = 1'b0;
    reset    = 1'b1;
    idle();
    step(2);
    reset = 1'b0;

    c = cyc_cnt;
    expectAt(c, A, F_EX_ALUOP,    0, "rst_ex_aluop");
    expectAt(c, A, F_MEM_RD,      0, "rst_mem_rd");
    expectAt(c, A, F_WB_REGWRITE, 0, "rst_wb_regwrite");
    expectAt(c, A, F_STALL_CNT,   0, "rst_stall_cnt");
    expectAt(c, B, F_FLUSH_CNT,   0, "rst_flush_cnt_b");

    // ADD X1,X2,X3 through all stages
    c = cyc_cnt;
    applyStimulus(OP_ADD, 5'd2, 5'd3, 5'd1, 1'b0);
    expectAt(c,   A, F_ILLEGAL,     0, "add_illegal");
    expectAt(c,   A, F_REG2LOC,     0, "add_reg2loc");
    expectAt(c,   A, F_STALL,       0, "add_stall");
    expectAt(c+1, A, F_EX_ALUOP,    2, "add_ex_aluop");
    expectAt(c+1, A, F_EX_ALUSRC,   0, "add_ex_alusrc");
    expectAt(c+1, A, F_EX_RD,       1, "add_ex_rd");
    expectAt(c+3, A, F_WB_REGWRITE, 1, "add_wb_regwrite");
    expectAt(c+3, A, F_WB_RD,       1, "add_wb_rd");
    expectAt(c+3, A, F_WB_MEMTOREG, 0, "add_wb_memtoreg");
    step(1); idle(); step(4);

    // LDUR X5 ; ADD using X5 via rn -> one-cycle bubble
    c = cyc_cnt;
    applyStimulus(OP_LDUR, 5'd1, 5'd0, 5'd5, 1'b0);
    expectAt(c+1, A, F_EX_ALUSRC, 1, "ldur_ex_alusrc");
    expectAt(c+1, A, F_EX_ALUOP,  0, "ldur_ex_aluop");
    step(1);
    applyStimulus(OP_ADD, 5'd5, 5'd6, 5'd8, 1'b0);
    expectAt(c+1, A, F_STALL,       1, "lu_stall_on");
    expectAt(c+1, B, F_STALL,       1, "lu_stall_on_b");
    expectAt(c+2, A, F_STALL,       0, "lu_stall_off");
    expectAt(c+2, A, F_EX_ALUSRC,   0, "bubble_alusrc");
    expectAt(c+2, A, F_EX_ALUOP,    0, "bubble_aluop");
    expectAt(c+2, A, F_EX_RD,       0, "bubble_rd");
    expectAt(c+2, A, F_MEM_MEMREAD, 1, "ldur_mem_memread");
    expectAt(c+2, A, F_MEM_RD,      5, "ldur_mem_rd");
    expectAt(c+2, A, F_STALL_CNT,   1, "lu_stall_cnt");
    expectAt(c+2, B, F_STALL_CNT,   1, "lu_stall_cnt_b");
    expectAt(c+3, A, F_EX_ALUOP,    2, "add_after_bubble_aluop");
    expectAt(c+3, A, F_EX_RD,       8, "add_after_bubble_rd");
    expectAt(c+3, A, F_WB_MEMTOREG, 1, "ldur_wb_memtoreg");
    expectAt(c+3, A, F_WB_RD,       5, "ldur_wb_rd");
    step(2); idle(); step(4);

    // LDUR X31 never stalls
    c = cyc_cnt;
    applyStimulus(OP_LDUR, 5'd1, 5'd0, 5'd31, 1'b0);
    step(1);
    applyStimulus(OP_ADD, 5'd31, 5'd2, 5'd4, 1'b0);
    expectAt(c+1, A, F_STALL,     0, "zr_no_stall");
    expectAt(c+2, A, F_EX_RD,     4, "zr_add_ex_rd");
    expectAt(c+2, A, F_EX_ALUOP,  2, "zr_add_ex_aluop");
    expectAt(c+2, A, F_STALL_CNT, 1, "zr_stall_cnt");
    step(1); idle(); step(4);

    // LDUR X7 ; STUR storing X7 -> stall through Reg2Loc source
    c = cyc_cnt;
    applyStimulus(OP_LDUR, 5'd1, 5'd0, 5'd7, 1'b0);
    step(1);
    applyStimulus(OP_STUR, 5'd2, 5'd9, 5'd7, 1'b0);
    expectAt(c+1, A, F_REG2LOC,      1, "stur_reg2loc");
    expectAt(c+1, A, F_STALL,        1, "stur_stall_on");
    expectAt(c+2, A, F_STALL,        0, "stur_stall_off");
    expectAt(c+2, A, F_STALL_CNT,    2, "stur_stall_cnt");
    expectAt(c+3, A, F_EX_ALUSRC,    1, "stur_ex_alusrc");
    expectAt(c+3, A, F_EX_RD,        7, "stur_ex_rd");
    expectAt(c+4, A, F_MEM_MEMWRITE, 1, "stur_mem_memwrite");
    step(2); idle(); step(4);

    // LDUR X7 ; CBZ with rn=7 but tested register X3 -> no stall
    c = cyc_cnt;
    applyStimulus(OP_LDUR, 5'd1, 5'd0, 5'd7, 1'b0);
    step(1);
    applyStimulus(OP_CBZ, 5'd7, 5'd7, 5'd3, 1'b0);
    expectAt(c+1, A, F_STALL,      0, "cbz_no_stall");
    expectAt(c+1, A, F_REG2LOC,    1, "cbz_reg2loc");
    expectAt(c+2, A, F_EX_ALUOP,   1, "cbz_ex_aluop");
    expectAt(c+2, A, F_EX_RD,      3, "cbz_ex_rd");
    expectAt(c+3, A, F_MEM_BRANCH, 1, "cbz_mem_branch");
    expectAt(c+3, A, F_MEM_BRNZ,   0, "cbz_mem_brnz");
    step(1); idle(); step(4);

    // Flush in the same cycle as a load-use hazard wins over the stall
    c = cyc_cnt;
    applyStimulus(OP_LDUR, 5'd1, 5'd0, 5'd5, 1'b0);
    step(1);
    applyStimulus(OP_ADD, 5'd5, 5'd6, 5'd8, 1'b1);
    expectAt(c+1, A, F_STALL,       0, "flush_no_stall");
    expectAt(c+2, A, F_EX_ALUOP,    0, "flush_ex_aluop");
    expectAt(c+2, A, F_EX_ALUSRC,   0, "flush_ex_alusrc");
    expectAt(c+2, A, F_EX_RD,       0, "flush_ex_rd");
    expectAt(c+2, A, F_MEM_MEMREAD, 0, "flush_mem_memread");
    expectAt(c+2, A, F_MEM_RD,      0, "flush_mem_rd");
    expectAt(c+2, A, F_FLUSH_CNT,   1, "flush_cnt");
    expectAt(c+2, A, F_STALL_CNT,   2, "flush_stall_cnt");
    expectAt(c+2, B, F_FLUSH_CNT,   1, "flush_cnt_b");
    step(1); idle(); step(4);

    // CBNZ: decoded in A, illegal in B
    c = cyc_cnt;
    applyStimulus(OP_CBNZ, 5'd0, 5'd0, 5'd2, 1'b0);
    expectAt(c,   A, F_ILLEGAL,    0, "cbnz_illegal");
    expectAt(c,   B, F_ILLEGAL,    1, "cbnz_illegal_b");
    expectAt(c,   A, F_REG2LOC,    1, "cbnz_reg2loc");
    expectAt(c,   B, F_REG2LOC,    0, "cbnz_reg2loc_b");
    expectAt(c+1, A, F_EX_ALUOP,   1, "cbnz_ex_aluop");
    expectAt(c+1, B, F_EX_ALUOP,   0, "cbnz_ex_aluop_b");
    expectAt(c+2, A, F_MEM_BRANCH, 1, "cbnz_mem_branch");
    expectAt(c+2, A, F_MEM_BRNZ,   1, "cbnz_mem_brnz");
    expectAt(c+2, B, F_MEM_BRANCH, 0, "cbnz_mem_branch_b");
    expectAt(c+2, B, F_MEM_BRNZ,   0, "cbnz_mem_brnz_b");
    step(1); idle(); step(4);

    // Unconditional B
    c = cyc_cnt;
    applyStimulus(OP_B, 5'd0, 5'd0, 5'd0, 1'b0);
    expectAt(c,   A, F_ILLEGAL,    0, "b_illegal");
    expectAt(c,   B, F_ILLEGAL,    1, "b_illegal_b");
    expectAt(c+2, A, F_MEM_UNCOND, 1, "b_mem_uncond");
    expectAt(c+2, A, F_MEM_BRANCH, 1, "b_mem_branch");
    expectAt(c+2, B, F_MEM_UNCOND, 0, "b_mem_uncond_b");
    step(1); idle(); step(4);

    // SUBI then ADDI
    c = cyc_cnt;
    applyStimulus(OP_SUBI, 5'd3, 5'd0, 5'd4, 1'b0);
    expectAt(c,   A, F_ILLEGAL,     0, "subi_illegal");
    expectAt(c,   B, F_ILLEGAL,     1, "subi_illegal_b");
    expectAt(c+1, A, F_EX_ALUSRC,   1, "subi_ex_alusrc");
    expectAt(c+1, A, F_EX_ALUOP,    3, "subi_ex_aluop");
    expectAt(c+1, A, F_EX_RD,       4, "subi_ex_rd");
    expectAt(c+1, B, F_EX_ALUSRC,   0, "subi_ex_alusrc_b");
    expectAt(c+3, A, F_WB_REGWRITE, 1, "subi_wb_regwrite");
    expectAt(c+3, A, F_WB_RD,       4, "subi_wb_rd");
    step(1);
    applyStimulus(OP_ADDI, 5'd3, 5'd0, 5'd6, 1'b0);
    expectAt(c+1, A, F_ILLEGAL,     0, "addi_illegal");
    expectAt(c+1, B, F_ILLEGAL,     1, "addi_illegal_b");
    expectAt(c+2, A, F_EX_ALUOP,    3, "addi_ex_aluop");
    expectAt(c+2, A, F_EX_RD,       6, "addi_ex_rd");
    expectAt(c+4, A, F_WB_RD,       6, "addi_wb_rd");
    step(1); idle(); step(4);

    // Four more load-use stalls: A counts to 6, B saturates at 3
    for (int k = 0; k < 4; k++) begin
      c = cyc_cnt;
      applyStimulus(OP_LDUR, 5'd1, 5'd0, 5'd10, 1'b0);
      step(1);
      applyStimulus(OP_ADD, 5'd10, 5'd1, 5'd11, 1'b0);
      expectAt(c+1, A, F_STALL, 1, "sat_stall_a");
      expectAt(c+1, B, F_STALL, 1, "sat_stall_b");
      step(2); idle(); step(2);
    end
    c = cyc_cnt;
    expectAt(c, A, F_STALL_CNT, 6, "stall_cnt_a_total");
    expectAt(c, B, F_STALL_CNT, 3, "stall_cnt_b_saturated");
    expectAt(c, B, F_FLUSH_CNT, 1, "flush_cnt_b_hold");

    // Reset while a load sits in EX/MEM
    c = cyc_cnt;
    applyStimulus(OP_LDUR, 5'd1, 5'd0, 5'd12, 1'b0);
    step(1); idle(); step(1);
    expectAt(c+2, A, F_MEM_MEMREAD, 1,  "prerst_mem_memread");
    expectAt(c+2, A, F_MEM_RD,      12, "prerst_mem_rd");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expectAt(c+3, A, F_MEM_MEMREAD, 0, "rst_mem_memread");
    expectAt(c+3, A, F_MEM_RD,      0, "rst_mem_rd2");
    expectAt(c+3, A, F_EX_RD,       0, "rst_ex_rd");
    expectAt(c+3, A, F_WB_MEMTOREG, 0, "rst_wb_memtoreg");
    expectAt(c+3, A, F_WB_RD,       0, "rst_wb_rd");
    expectAt(c+3, A, F_STALL_CNT,   0, "rst_stall_cnt_a");
    expectAt(c+3, A, F_FLUSH_CNT,   0, "rst_flush_cnt_a");
    expectAt(c+3, B, F_STALL_CNT,   0, "rst_stall_cnt_b");
    expectAt(c+3, B, F_FLUSH_CNT,   0, "rst_flush_cnt_b");
    step(3);

    done = 1'b1;
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: expectation for cycle %0d never checked (now %0d)",
               sb[0].name, sb[0].cyc, cyc_cnt);
      sb.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
